// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader: FSM state encodings and
// the default word width.
package serial_word_loader_pkg;

  // Default word length, matching the 16-bit storage register downstream.
  localparam int unsigned SWL_DEFAULT_WIDTH = 16;

  // FSM state encodings (IDLE=0, SHIFT=1, EMIT=2).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

endpackage : serial_word_loader_pkg

// File: rtl/shift_in_reg.sv
// shift_in_reg: WIDTH-bit serial-in shift register with enable, synchronous
// clear, asynchronous active-low reset and selectable shift direction.
//
// Ports:
//   clk       in   clock
//   rst_n     in   async active-low reset, register -> 0
//   i_clr     in   sync clear, register -> 0 (priority over i_en)
//   i_en      in   shift i_bit in this cycle
//   i_start   in   with i_en: discard current contents, i_bit becomes bit 1
//   i_bit     in   serial data bit
//   o_next_c  out  comb: register value after this cycle's shift
module shift_in_reg
  import serial_word_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = SWL_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_next_c
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next;

  // A frame start shifts into an empty register so stale bits never leak.
  assign w_base = i_start ? '0 : r_q;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_next = {w_base[WIDTH-2:0], i_bit};
    end else begin : g_lsb_first
      assign w_next = {i_bit, w_base[WIDTH-1:1]};
    end
  endgenerate

  // Shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

  assign o_next_c = w_next;

endmodule : shift_in_reg

// File: rtl/serial_word_loader.sv
// serial_word_loader: deserialises a framed bit stream into a WIDTH-bit word
// and issues a one-cycle load pulse with a stable word, suitable for driving
// a storage register's in/load directly.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   async active-low reset
//   clear      in   sync abort of the frame in progress
//   sin        in   serial data bit
//   sin_valid  in   sin is valid this cycle
//   sin_sof    in   sin is bit 1 of a frame
//   sin_ready  out  comb: a bit can be accepted this cycle
//   word       out  last completed word, stable between completions
//   load       out  one-cycle pulse, word valid
//   busy       out  frame in progress or being emitted
//   frame_err  out  one-cycle pulse on a framing violation
//   count      out  bits accepted in the current frame
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = SWL_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_sof,
  output logic             sin_ready,
  output logic [WIDTH-1:0] word,
  output logic             load,
  output logic             busy,
  output logic             frame_err,
  output logic [CW-1:0]    count
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_word_nxt;
  logic             r_load;
  logic             w_load_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_ready;
  logic             w_accept;
  logic             w_sr_en;
  logic             w_sr_start;
  logic [WIDTH-1:0] w_sr_next;

  // Ready drops while in reset and during the single EMIT cycle.
  assign w_ready  = rst_n && (r_state != ST_EMIT);
  assign w_accept = sin_valid && w_ready;

  shift_in_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (clear),
    .i_en     (w_sr_en),
    .i_start  (w_sr_start),
    .i_bit    (sin),
    .o_next_c (w_sr_next)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_word  <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_word  <= w_word_nxt;
      r_load  <= w_load_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, counter, word capture and pulse generation.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_word_nxt  = r_word;
    w_load_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_sr_en     = 1'b0;
    w_sr_start  = 1'b0;

    if (clear) begin
      // Abort drops any bit offered this cycle; word is kept.
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (sin_sof) begin
              w_sr_en     = 1'b1;
              w_sr_start  = 1'b1;
              w_count_nxt = CW'(1);
              w_state_nxt = ST_SHIFT;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          if (w_accept) begin
            w_sr_en = 1'b1;
            if (sin_sof) begin
              // Early start of frame: restart with this bit as bit 1.
              w_sr_start  = 1'b1;
              w_count_nxt = CW'(1);
              w_err_nxt   = 1'b1;
            end else if (r_count == CW'(WIDTH - 1)) begin
              w_word_nxt  = w_sr_next;
              w_count_nxt = CW'(WIDTH);
              w_load_nxt  = 1'b1;
              w_state_nxt = ST_EMIT;
            end else begin
              w_count_nxt = r_count + CW'(1);
            end
          end
        end

        ST_EMIT: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  assign sin_ready = w_ready;
  assign word      = r_word;
  assign load      = r_load;
  assign frame_err = r_err;
  assign count     = r_count;
  assign busy      = (r_state != ST_IDLE);

endmodule : serial_word_loader
